// File: rtl/cordic_iter_sequencer_if.sv
// Operand-in / result-out handshake bundle for the CORDIC iteration sequencer.
interface cordic_iter_sequencer_if #(
  parameter int unsigned DSIZE = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] x_in;
  logic [DSIZE-1:0] y_in;
  logic [DSIZE-1:0] z_in;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] x_out;
  logic [DSIZE-1:0] y_out;
  logic [DSIZE-1:0] z_out;

  // Producer/consumer side: offers operands, takes results.
  modport master (
    output in_valid, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out
  );

  // Sequencer side.
  modport slave (
    input  in_valid, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out
  );
endinterface

// File: rtl/cordic_iter_sequencer.sv
// Iteration controller for a CORDIC rotation stage: loads one operand set,
// walks I = 0..ITER-1 feeding stage results back, then presents the result.
module cordic_iter_sequencer #(
  parameter int unsigned DSIZE    = 16,
  parameter int unsigned ITER     = 16,
  parameter int unsigned ROT_LAT  = 1,
  parameter string       ROTTMODE = "ROTT"
) (
  input  logic             clock,
  input  logic             rst_n,
  cordic_iter_sequencer_if.slave io,
  output logic [DSIZE-1:0] rot_Xin,
  output logic [DSIZE-1:0] rot_Yin,
  output logic [DSIZE-1:0] rot_Zin,
  output logic [4:0]       rot_I,
  output logic             rot_direcion,
  input  logic [DSIZE-1:0] rot_Xout,
  input  logic [DSIZE-1:0] rot_Yout,
  input  logic [DSIZE-1:0] rot_Zout,
  output logic             busy
);

  localparam int unsigned   WCNT_W    = (ROT_LAT > 1) ? $clog2(ROT_LAT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(ROT_LAT - 1);
  localparam logic [4:0]    ITER_LAST = 5'(ITER - 1);
  localparam bit            IS_VECTOR = (ROTTMODE == "VECTOR");

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_n;
  logic [DSIZE-1:0]  x_r, y_r, z_r;
  logic [4:0]        iter;
  logic [WCNT_W-1:0] wcnt;
  logic              out_valid_q;
  logic              accept;
  logic              capture;

  // Next state plus the load/capture strobes for the datapath.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (io.in_valid) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (wcnt == WCNT_LAST) begin
          capture = 1'b1;
          if (iter == ITER_LAST) state_n = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register with registered status flags decoded from the next state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      out_valid_q <= (state_n == DONE);
      busy        <= (state_n != IDLE);
    end
  end

  // Operand registers, iteration index and per-iteration wait counter.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      x_r  <= '0;
      y_r  <= '0;
      z_r  <= '0;
      iter <= '0;
      wcnt <= '0;
    end else if (accept) begin
      x_r  <= io.x_in;
      y_r  <= io.y_in;
      z_r  <= io.z_in;
      iter <= '0;
      wcnt <= '0;
    end else if (capture) begin
      x_r  <= rot_Xout;
      y_r  <= rot_Yout;
      z_r  <= rot_Zout;
      wcnt <= '0;
      if (iter != ITER_LAST) iter <= iter + 5'd1;
    end else if (state == RUN) begin
      wcnt <= wcnt + WCNT_W'(1);
    end
  end

  // Held registers drive the stage and the result bus for a whole iteration.
  assign rot_Xin      = x_r;
  assign rot_Yin      = y_r;
  assign rot_Zin      = z_r;
  assign rot_I        = iter;
  assign rot_direcion = IS_VECTOR ? y_r[DSIZE-1] : ~z_r[DSIZE-1];
  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = out_valid_q;
  assign io.x_out     = x_r;
  assign io.y_out     = y_r;
  assign io.z_out     = z_r;

endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// Directed bench: three sequencers (ROTT lat 1, ROTT lat 3, VECTOR lat 1),
// each closed around a behavioural rotation stage.
module tb_cordic_iter_sequencer;

  logic        clk;
  logic        rst_n;
  logic [2:0]  iv, ordy;
  logic [15:0] xi, yi, zi;
  int          vectors;
  int          miscompares;

  logic [2:0]  ov, ir, bsy, dr;
  logic [4:0]  ri [3];
  logic [15:0] rxi [3], ryi [3], rzi [3];
  logic [15:0] rxo [3], ryo [3], rzo [3];
  logic [15:0] xo [3], yo [3], zo [3];
  logic [47:0] p1a, p1b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cordic_iter_sequencer_if #(.DSIZE(16)) io0 ();
  cordic_iter_sequencer_if #(.DSIZE(16)) io1 ();
  cordic_iter_sequencer_if #(.DSIZE(16)) io2 ();

  assign io0.in_valid = iv[0];   assign io1.in_valid = iv[1];   assign io2.in_valid = iv[2];
  assign io0.out_ready = ordy[0]; assign io1.out_ready = ordy[1]; assign io2.out_ready = ordy[2];
  assign io0.x_in = xi; assign io0.y_in = yi; assign io0.z_in = zi;
  assign io1.x_in = xi; assign io1.y_in = yi; assign io1.z_in = zi;
  assign io2.x_in = xi; assign io2.y_in = yi; assign io2.z_in = zi;
  assign ov = {io2.out_valid, io1.out_valid, io0.out_valid};
  assign ir = {io2.in_ready, io1.in_ready, io0.in_ready};
  assign xo[0] = io0.x_out; assign yo[0] = io0.y_out; assign zo[0] = io0.z_out;
  assign xo[1] = io1.x_out; assign yo[1] = io1.y_out; assign zo[1] = io1.z_out;
  assign xo[2] = io2.x_out; assign yo[2] = io2.y_out; assign zo[2] = io2.z_out;

  cordic_iter_sequencer #(.DSIZE(16), .ITER(16), .ROT_LAT(1), .ROTTMODE("ROTT")) u0 (
    .clock(clk), .rst_n(rst_n), .io(io0.slave),
    .rot_Xin(rxi[0]), .rot_Yin(ryi[0]), .rot_Zin(rzi[0]), .rot_I(ri[0]), .rot_direcion(dr[0]),
    .rot_Xout(rxo[0]), .rot_Yout(ryo[0]), .rot_Zout(rzo[0]), .busy(bsy[0]));

  cordic_iter_sequencer #(.DSIZE(16), .ITER(16), .ROT_LAT(3), .ROTTMODE("ROTT")) u1 (
    .clock(clk), .rst_n(rst_n), .io(io1.slave),
    .rot_Xin(rxi[1]), .rot_Yin(ryi[1]), .rot_Zin(rzi[1]), .rot_I(ri[1]), .rot_direcion(dr[1]),
    .rot_Xout(rxo[1]), .rot_Yout(ryo[1]), .rot_Zout(rzo[1]), .busy(bsy[1]));

  cordic_iter_sequencer #(.DSIZE(16), .ITER(16), .ROT_LAT(1), .ROTTMODE("VECTOR")) u2 (
    .clock(clk), .rst_n(rst_n), .io(io2.slave),
    .rot_Xin(rxi[2]), .rot_Yin(ryi[2]), .rot_Zin(rzi[2]), .rot_I(ri[2]), .rot_direcion(dr[2]),
    .rot_Xout(rxo[2]), .rot_Yout(ryo[2]), .rot_Zout(rzo[2]), .busy(bsy[2]));

  function automatic logic [15:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0: return 16'h2000;  5'd1: return 16'h12E4;  5'd2: return 16'h09FB;
      5'd3: return 16'h0511;  5'd4: return 16'h028B;  5'd5: return 16'h0146;
      5'd6: return 16'h00A3;  5'd7: return 16'h0051;  5'd8: return 16'h0029;
      5'd9: return 16'h0014;  5'd10: return 16'h000A; 5'd11: return 16'h0005;
      5'd12: return 16'h0003; 5'd13: return 16'h0001; 5'd14: return 16'h0001;
      default: return 16'h0000;
    endcase
  endfunction

  // One micro-rotation of the stage; direction 1 rotates counter-clockwise.
  function automatic logic [47:0] rot_step(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] z, input logic [4:0] i,
                                           input logic d);
    logic [15:0] sx, sy, a, xn, yn, zn;
    sx = 16'($signed(x) >>> i);
    sy = 16'($signed(y) >>> i);
    a  = atan_lut(i);
    if (d) begin xn = x - sy; yn = y + sx; zn = z - a; end
    else   begin xn = x + sy; yn = y - sx; zn = z + a; end
    return {xn, yn, zn};
  endfunction

  // Operands after n sequential iterations, direction chosen from the held values.
  function automatic logic [47:0] ref_run(input logic [15:0] x0, input logic [15:0] y0,
                                          input logic [15:0] z0, input int n, input bit vec);
    logic [47:0] v;
    logic        d;
    v = {x0, y0, z0};
    for (int i = 0; i < n; i++) begin
      d = vec ? v[31] : ~v[15];
      v = rot_step(v[47:32], v[31:16], v[15:0], 5'(i), d);
    end
    return v;
  endfunction

  // Lat-1 stages answer within the cycle; the lat-3 stage is pipelined so its
  // result becomes capturable on the third edge after the operands settle.
  assign {rxo[0], ryo[0], rzo[0]} = rot_step(rxi[0], ryi[0], rzi[0], ri[0], dr[0]);
  assign {rxo[2], ryo[2], rzo[2]} = rot_step(rxi[2], ryi[2], rzi[2], ri[2], dr[2]);
  always @(posedge clk) begin
    p1a <= rot_step(rxi[1], ryi[1], rzi[1], ri[1], dr[1]);
    p1b <= p1a;
  end
  assign {rxo[1], ryo[1], rzo[1]} = p1b;

  task automatic accept(input int n, input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    xi = x; yi = y; zi = z;
    iv[n] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[n] = 1'b0;
  endtask

  task automatic wait_done(input int n, output int cyc);
    cyc = 0;
    while (!ov[n] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!ov[n]) begin
      miscompares++;
      $display("FAIL wait_done[%0d]: out_valid never rose within %0d cycles", n, cyc);
    end
  endtask

  task automatic drain(input int n);
    ordy[n] = 1'b1;
    @(negedge clk);
    ordy[n] = 1'b0;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 3; n++) begin
      vectors++;
      if ({ir[n], ov[n], bsy[n]} !== 3'b100 || ri[n] !== 5'd0 || rxi[n] !== 16'h0 ||
          ryi[n] !== 16'h0 || rzi[n] !== 16'h0 || xo[n] !== 16'h0 || yo[n] !== 16'h0 || zo[n] !== 16'h0) begin
        miscompares++;
        $display("FAIL reset[%0d]: rdy/vld/busy=%b rot_I=%h x=%h y=%h z=%h, expected 100 and zeros",
                 n, {ir[n], ov[n], bsy[n]}, ri[n], xo[n], yo[n], zo[n]);
      end
    end
  endtask

  task automatic test_basic();
    logic [47:0] e;
    accept(0, 16'h4000, 16'h0000, 16'h1000);
    for (int k = 0; k < 16; k++) begin
      e = ref_run(16'h4000, 16'h0000, 16'h1000, k, 1'b0);
      vectors++;
      if (ri[0] !== 5'(k) || ov[0] !== 1'b0 || bsy[0] !== 1'b1 || ir[0] !== 1'b0 ||
          {rxi[0], ryi[0], rzi[0]} !== e) begin
        miscompares++;
        $display("FAIL basic_step%0d: I=%0d vld=%b busy=%b rdy=%b ops=%h, expected I=%0d 0 1 0 ops=%h",
                 k, ri[0], ov[0], bsy[0], ir[0], {rxi[0], ryi[0], rzi[0]}, k, e);
      end
      @(negedge clk);
    end
    e = ref_run(16'h4000, 16'h0000, 16'h1000, 16, 1'b0);
    vectors++;
    if (ov[0] !== 1'b1 || {xo[0], yo[0], zo[0]} !== e) begin
      miscompares++;
      $display("FAIL basic_result: vld=%b out=%h, expected 1 %h", ov[0], {xo[0], yo[0], zo[0]}, e);
    end
    drain(0);
    vectors++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain: vld=%b rdy=%b busy=%b, expected 0 1 0", ov[0], ir[0], bsy[0]);
    end
  endtask

  task automatic test_direction();
    int          cyc;
    logic [47:0] e;
    logic [15:0] zv [2];
    logic [15:0] yv [2];
    logic        de [2];
    zv[0] = 16'h0000; zv[1] = 16'hFFFF; yv[0] = 16'h8000; yv[1] = 16'h0001;
    de[0] = 1'b1;     de[1] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      accept(0, 16'h4000, 16'h0000, zv[j]);
      vectors++;
      if (dr[0] !== de[j]) begin
        miscompares++;
        $display("FAIL dir_rott z=%h: got %b expected %b", zv[j], dr[0], de[j]);
      end
      wait_done(0, cyc);
      drain(0);
      accept(2, 16'h3000, yv[j], 16'h0000);
      vectors++;
      if (dr[2] !== de[j]) begin
        miscompares++;
        $display("FAIL dir_vector y=%h: got %b expected %b", yv[j], dr[2], de[j]);
      end
      wait_done(2, cyc);
      e = ref_run(16'h3000, yv[j], 16'h0000, 16, 1'b1);
      vectors++;
      if ({xo[2], yo[2], zo[2]} !== e || cyc != 16) begin
        miscompares++;
        $display("FAIL vector_result y=%h: out=%h cyc=%0d, expected %h 16", yv[j], {xo[2], yo[2], zo[2]}, cyc, e);
      end
      drain(2);
    end
  endtask

  task automatic test_lat3();
    logic [47:0] e;
    accept(1, 16'h3000, 16'h1000, 16'h0800);
    for (int c = 0; c < 48; c++) begin
      e = ref_run(16'h3000, 16'h1000, 16'h0800, c / 3, 1'b0);
      vectors++;
      if (ri[1] !== 5'(c / 3) || ov[1] !== 1'b0 || {rxi[1], ryi[1], rzi[1]} !== e) begin
        miscompares++;
        $display("FAIL lat3_cycle%0d: I=%0d vld=%b ops=%h, expected I=%0d 0 ops=%h",
                 c, ri[1], ov[1], {rxi[1], ryi[1], rzi[1]}, c / 3, e);
      end
      @(negedge clk);
    end
    e = ref_run(16'h3000, 16'h1000, 16'h0800, 16, 1'b0);
    vectors++;
    if (ov[1] !== 1'b1 || {xo[1], yo[1], zo[1]} !== e) begin
      miscompares++;
      $display("FAIL lat3_result: vld=%b out=%h, expected 1 %h", ov[1], {xo[1], yo[1], zo[1]}, e);
    end
    drain(1);
  endtask

  task automatic test_backpressure();
    int          cyc;
    logic [47:0] e;
    e = ref_run(16'h2000, 16'h2000, 16'hF000, 16, 1'b0);
    accept(0, 16'h2000, 16'h2000, 16'hF000);
    wait_done(0, cyc);
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || bsy[0] !== 1'b1 || {xo[0], yo[0], zo[0]} !== e) begin
        miscompares++;
        $display("FAIL backpressure%0d: vld=%b rdy=%b busy=%b out=%h, expected 1 0 1 %h",
                 k, ov[0], ir[0], bsy[0], {xo[0], yo[0], zo[0]}, e);
      end
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    vectors++;
    if (ir[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL done_ready_low: in_ready=%b with out_ready high in DONE, expected 0", ir[0]);
    end
    @(negedge clk);
    ordy[0] = 1'b0;
    vectors++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_release: vld=%b rdy=%b, expected 0 1", ov[0], ir[0]);
    end
  endtask

  task automatic test_no_recapture();
    int          cyc;
    logic [47:0] e;
    e = ref_run(16'h1800, 16'hF800, 16'h0400, 16, 1'b0);
    @(negedge clk);
    xi = 16'h1800; yi = 16'hF800; zi = 16'h0400;
    iv[0] = 1'b1;
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    while (!ov[0] && cyc < 40) begin
      xi = xi + 16'h0111; yi = yi - 16'h0222; zi = zi + 16'h0333;
      @(negedge clk);
      cyc++;
    end
    iv[0] = 1'b0;
    vectors++;
    if (ov[0] !== 1'b1 || cyc != 16 || {xo[0], yo[0], zo[0]} !== e) begin
      miscompares++;
      $display("FAIL no_recapture: vld=%b cyc=%0d out=%h, expected 1 16 %h", ov[0], cyc, {xo[0], yo[0], zo[0]}, e);
    end
    drain(0);
  endtask

  task automatic test_reset_midrun();
    int          cyc;
    logic [47:0] e;
    accept(0, 16'h4000, 16'h0000, 16'h1000);
    repeat (7) @(negedge clk);
    vectors++;
    if (ri[0] !== 5'd7) begin
      miscompares++;
      $display("FAIL midrun_index: rot_I=%0d expected 7", ri[0]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ir[0], ov[0], bsy[0]} !== 3'b100 || ri[0] !== 5'd0 || {rxi[0], ryi[0], rzi[0]} !== 48'h0 ||
        {xo[0], yo[0], zo[0]} !== 48'h0) begin
      miscompares++;
      $display("FAIL midrun_reset: rdy/vld/busy=%b I=%0d ops=%h out=%h, expected 100 0 zeros",
               {ir[0], ov[0], bsy[0]}, ri[0], {rxi[0], ryi[0], rzi[0]}, {xo[0], yo[0], zo[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    e = ref_run(16'h1234, 16'h0567, 16'hE000, 16, 1'b0);
    accept(0, 16'h1234, 16'h0567, 16'hE000);
    wait_done(0, cyc);
    vectors++;
    if (cyc != 16 || {xo[0], yo[0], zo[0]} !== e) begin
      miscompares++;
      $display("FAIL post_reset_run: cyc=%0d out=%h, expected 16 %h", cyc, {xo[0], yo[0], zo[0]}, e);
    end
    drain(0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; iv = '0; ordy = '0;
    xi = '0; yi = '0; zi = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_direction();
    test_lat3();
    test_backpressure();
    test_no_recapture();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
